// File: rtl/multi_pkg.sv
// Shared constants and types for the LM/SM micro-op expansion stage.
// Latency: none, declarations only.
// Backpressure: not applicable.
package multi_pkg;
    localparam int DATA_W  = 16;
    localparam int MASK_W  = 8;
    localparam int REG_W   = 3;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int RA_HI   = 11;
    localparam int RA_LO   = 9;
    localparam int MASK_HI = 7;
    localparam int MASK_LO = 0;

    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] ir;
        logic [DATA_W-1:0] pc;
        logic [REG_W-1:0]  rsel;
        logic [REG_W-1:0]  offset;
        logic              first;
        logic              last;
    } beat_t;

    function automatic logic is_multi(input logic [3:0] opc);
        return (opc == OP_LM) || (opc == OP_SM);
    endfunction
endpackage

// File: rtl/multi_sequencer_lowest_set_enc.sv
// Priority encoder returning the index of the lowest set mask bit.
// Latency: combinational.
// Backpressure: none.
module lowest_set_enc
    import multi_pkg::*;
(
    input  logic [MASK_W-1:0] mask,
    output logic [REG_W-1:0]  idx,
    output logic              found
);
    // Scan high to low so the lowest set bit is the final assignment.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = REG_W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/multi_sequencer.sv
// Splits LM/SM into one beat per mask bit (R0 first); other ops pass through. Optional: MULTI_EMPTY_PASS_EN.
// Latency: one cycle per beat; a k-bit LM/SM issues k beats on consecutive unstalled cycles.
// Backpressure: stall freezes everything; in_ready/fetch_hold hold upstream while bits remain pending.
module multi_sequencer
    import multi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_ir,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              stall,
    input  logic              flush,
    output logic              in_ready,
    output logic              fetch_hold,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_ir,
    output logic [DATA_W-1:0] out_pc,
    output logic [REG_W-1:0]  out_reg,
    output logic [REG_W-1:0]  out_offset,
    output logic              out_first,
    output logic              out_last
);
    logic [MASK_W-1:0] pending, pending_d;
    logic [MASK_W-1:0] enc_mask, onehot, rest;
    logic [REG_W-1:0]  enc_idx;
    logic              enc_found;
    beat_t             beat_q, beat_d;

    assign fetch_hold = (pending != '0);
    assign in_ready   = !fetch_hold && !stall;

    // One encoder serves both the capture beat and the remaining-bit beats.
    assign enc_mask = fetch_hold ? pending : in_ir[MASK_HI:MASK_LO];
    assign onehot   = 8'b1 << enc_idx;
    assign rest     = enc_mask & ~onehot;

    lowest_set_enc u_enc (
        .mask  (enc_mask),
        .idx   (enc_idx),
        .found (enc_found)
    );

    always_comb begin
        pending_d = pending;
        beat_d    = beat_q;
        if (flush) begin
            pending_d    = '0;
            beat_d.vld   = 1'b0;
            beat_d.first = 1'b0;
            beat_d.last  = 1'b0;
        end else if (!stall) begin
            if (fetch_hold) begin
                pending_d     = rest;
                beat_d.vld    = 1'b1;
                beat_d.ir     = {beat_q.ir[DATA_W-1:MASK_W], onehot};
                beat_d.rsel   = enc_idx;
                beat_d.offset = (beat_q.offset == 3'd7) ? 3'd7 : beat_q.offset + 3'd1;
                beat_d.first  = 1'b0;
                beat_d.last   = (rest == '0);
            end else if (in_valid) begin
                beat_d.vld    = 1'b1;
                beat_d.ir     = in_ir;
                beat_d.pc     = in_pc;
                beat_d.rsel   = '0;
                beat_d.offset = '0;
                beat_d.first  = 1'b1;
                beat_d.last   = 1'b1;
                if (is_multi(in_ir[OPC_HI:OPC_LO])) begin
                    if (enc_found) begin
                        pending_d   = rest;
                        beat_d.ir   = {in_ir[DATA_W-1:MASK_W], onehot};
                        beat_d.rsel = enc_idx;
                        beat_d.last = (rest == '0);
                    end else begin
`ifdef MULTI_EMPTY_PASS_EN
                        beat_d.rsel = '0;
`else
                        // Empty mask is consumed without producing a beat.
                        beat_d     = beat_q;
                        beat_d.vld = 1'b0;
`endif
                    end
                end
            end else begin
                beat_d.vld = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            beat_q  <= '0;
        end else begin
            pending <= pending_d;
            beat_q  <= beat_d;
        end
    end

    assign out_valid  = beat_q.vld;
    assign out_ir     = beat_q.ir;
    assign out_pc     = beat_q.pc;
    assign out_reg    = beat_q.rsel;
    assign out_offset = beat_q.offset;
    assign out_first  = beat_q.first;
    assign out_last   = beat_q.last;
endmodule

// File: tb/tb_multi_sequencer.sv
// Directed bench for multi_sequencer: reset, LM/SM expansion, pass-through, stall, flush, empty mask.
module tb_multi_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_ir;
    logic [15:0] in_pc;
    logic        stall;
    logic        flush;
    logic        in_ready;
    logic        fetch_hold;
    logic        out_valid;
    logic [15:0] out_ir;
    logic [15:0] out_pc;
    logic [2:0]  out_reg;
    logic [2:0]  out_offset;
    logic        out_first;
    logic        out_last;

    int checks   = 0;
    int failures = 0;

    multi_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ir      (in_ir),
        .in_pc      (in_pc),
        .stall      (stall),
        .flush      (flush),
        .in_ready   (in_ready),
        .fetch_hold (fetch_hold),
        .out_valid  (out_valid),
        .out_ir     (out_ir),
        .out_pc     (out_pc),
        .out_reg    (out_reg),
        .out_offset (out_offset),
        .out_first  (out_first),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic v, input logic [15:0] ir,
                            input logic [15:0] pc, input logic [2:0] r, input logic [2:0] off,
                            input logic f, input logic l);
        chk({tag, ".valid"},  16'(out_valid),  16'(v));
        chk({tag, ".ir"},     out_ir,          ir);
        chk({tag, ".pc"},     out_pc,          pc);
        chk({tag, ".reg"},    16'(out_reg),    16'(r));
        chk({tag, ".offset"}, 16'(out_offset), 16'(off));
        chk({tag, ".first"},  16'(out_first),  16'(f));
        chk({tag, ".last"},   16'(out_last),   16'(l));
    endtask

    task automatic chk_hs(input string tag, input logic rdy, input logic hold);
        chk({tag, ".in_ready"},   16'(in_ready),   16'(rdy));
        chk({tag, ".fetch_hold"}, 16'(fetch_hold), 16'(hold));
    endtask

    initial begin
        logic [7:0] one;
        rst_n = 1'b1; in_valid = 1'b0; in_ir = '0; in_pc = '0; stall = 1'b0; flush = 1'b0;

        // Reset asserted mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk_beat("rst", 1'b0, 16'h0000, 16'h0000, 3'd0, 3'd0, 1'b0, 1'b0);
        chk_hs("rst", 1'b1, 1'b0);
        #9 rst_n = 1'b1;

        // LM RA=2 mask A5
        in_valid = 1'b1; in_ir = 16'h64A5; in_pc = 16'h0010;
        tick();
        chk_beat("lm_b1", 1'b1, 16'h6401, 16'h0010, 3'd0, 3'd0, 1'b1, 1'b0);
        chk_hs("lm_b1", 1'b0, 1'b1);
        tick();
        chk_beat("lm_b2", 1'b1, 16'h6404, 16'h0010, 3'd2, 3'd1, 1'b0, 1'b0);
        chk_hs("lm_b2", 1'b0, 1'b1);
        tick();
        chk_beat("lm_b3", 1'b1, 16'h6420, 16'h0010, 3'd5, 3'd2, 1'b0, 1'b0);
        chk_hs("lm_b3", 1'b0, 1'b1);
        tick();
        chk_beat("lm_b4", 1'b1, 16'h6480, 16'h0010, 3'd7, 3'd3, 1'b0, 1'b1);
        chk_hs("lm_b4", 1'b1, 1'b0);

        // ADD then SM mask 01, back to back
        in_ir = 16'h1234; in_pc = 16'h0020;
        tick();
        chk_beat("add", 1'b1, 16'h1234, 16'h0020, 3'd0, 3'd0, 1'b1, 1'b1);
        chk_hs("add", 1'b1, 1'b0);
        in_ir = 16'h7001; in_pc = 16'h0022;
        tick();
        chk_beat("sm01", 1'b1, 16'h7001, 16'h0022, 3'd0, 3'd0, 1'b1, 1'b1);
        chk_hs("sm01", 1'b1, 1'b0);
        in_valid = 1'b0;
        tick();
        chk_beat("idle", 1'b0, 16'h7001, 16'h0022, 3'd0, 3'd0, 1'b1, 1'b1);

        // SM mask FF with a two-cycle stall on beat 3
        in_valid = 1'b1; in_ir = 16'h7EFF; in_pc = 16'h0030;
        tick();
        chk_beat("ff_b1", 1'b1, 16'h7E01, 16'h0030, 3'd0, 3'd0, 1'b1, 1'b0);
        tick();
        chk_beat("ff_b2", 1'b1, 16'h7E02, 16'h0030, 3'd1, 3'd1, 1'b0, 1'b0);
        tick();
        chk_beat("ff_b3", 1'b1, 16'h7E04, 16'h0030, 3'd2, 3'd2, 1'b0, 1'b0);
        stall = 1'b1;
        #1 chk_hs("ff_stall", 1'b0, 1'b1);
        tick();
        chk_beat("ff_s1", 1'b1, 16'h7E04, 16'h0030, 3'd2, 3'd2, 1'b0, 1'b0);
        tick();
        chk_beat("ff_s2", 1'b1, 16'h7E04, 16'h0030, 3'd2, 3'd2, 1'b0, 1'b0);
        stall = 1'b0;
        for (int r = 3; r <= 7; r++) begin
            tick();
            one = 8'b1 << r;
            chk_beat("ff_bn", 1'b1, {8'h7E, one}, 16'h0030, 3'(r), 3'(r), 1'b0, r == 7);
            chk_hs("ff_bn", r == 7, r != 7);
        end
        in_valid = 1'b0;

        // LM mask 0F flushed at beat 2
        in_valid = 1'b1; in_ir = 16'h600F; in_pc = 16'h0040;
        tick();
        chk_beat("fl_b1", 1'b1, 16'h6001, 16'h0040, 3'd0, 3'd0, 1'b1, 1'b0);
        tick();
        chk_beat("fl_b2", 1'b1, 16'h6002, 16'h0040, 3'd1, 3'd1, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        chk("fl.valid", 16'(out_valid), 16'h0);
        chk("fl.first", 16'(out_first), 16'h0);
        chk("fl.last",  16'(out_last),  16'h0);
        chk_hs("fl", 1'b1, 1'b0);
        flush = 1'b0; in_ir = 16'h2345; in_pc = 16'h0050;
        tick();
        chk_beat("post_fl", 1'b1, 16'h2345, 16'h0050, 3'd0, 3'd0, 1'b1, 1'b1);

        // Zero-mask LM
        in_ir = 16'h6000; in_pc = 16'h0060;
        #1 chk_hs("lm0_pre", 1'b1, 1'b0);
        tick();
`ifdef MULTI_EMPTY_PASS_EN
        chk_beat("lm0", 1'b1, 16'h6000, 16'h0060, 3'd0, 3'd0, 1'b1, 1'b1);
`else
        chk("lm0.valid", 16'(out_valid), 16'h0);
`endif
        chk_hs("lm0", 1'b1, 1'b0);
        in_valid = 1'b0;

        // Reset in the middle of an expansion
        in_valid = 1'b1; in_ir = 16'h60F0; in_pc = 16'h0070;
        tick();
        chk_beat("rx_b1", 1'b1, 16'h6010, 16'h0070, 3'd4, 3'd0, 1'b1, 1'b0);
        tick();
        chk_beat("rx_b2", 1'b1, 16'h6020, 16'h0070, 3'd5, 3'd1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_beat("rx_rst", 1'b0, 16'h0000, 16'h0000, 3'd0, 3'd0, 1'b0, 1'b0);
        chk_hs("rx_rst", 1'b1, 1'b0);
        #1 rst_n = 1'b1;
        tick();
        chk("rx_idle.valid", 16'(out_valid), 16'h0);
        chk_hs("rx_idle", 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
